// File: rtl/fpu_defs_fmac.sv
// Shared FMAC definitions: datapath widths and small helpers used by the
// FMAC issue arbiter and its round-robin selector.
package fpu_defs_fmac;

  localparam int unsigned C_FMAC_WIDTH = 32;
  localparam int unsigned C_RM_WIDTH   = 3;
  localparam int unsigned C_FLAG_WIDTH = 5;

  // Increment an index modulo n (used for the round-robin pointer).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_tree_fmac.sv
// Combinational round-robin selector: picks the lowest-indexed requester at
// or above the priority pointer, wrapping modulo NUM_REQ.
module rr_arb_tree_fmac #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   prio_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  int unsigned j;
  logic        found;

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(prio_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/fmac_arbiter.sv
// Shares one pipelined FMAC datapath among C_NUM_REQ requesters. Tracks
// in-flight ops as a {valid, tag} shift register, routes results back by tag
// and freezes the whole pipe while the owning requester is not ready.
module fmac_arbiter
  import fpu_defs_fmac::*;
#(
  parameter int unsigned C_NUM_REQ = 4,
  parameter int unsigned C_LAT     = 3
) (
  input  logic                                     Clk_CI,
  input  logic                                     Rst_RI,
  input  logic [C_NUM_REQ-1:0]                     Req_SI,
  input  logic [C_NUM_REQ-1:0][C_FMAC_WIDTH-1:0]   OpA_DI,
  input  logic [C_NUM_REQ-1:0][C_FMAC_WIDTH-1:0]   OpB_DI,
  input  logic [C_NUM_REQ-1:0][C_FMAC_WIDTH-1:0]   OpC_DI,
  input  logic [C_NUM_REQ-1:0][C_RM_WIDTH-1:0]     RM_DI,
  output logic [C_NUM_REQ-1:0]                     Gnt_SO,
  output logic [C_FMAC_WIDTH-1:0]                  OpA_DO,
  output logic [C_FMAC_WIDTH-1:0]                  OpB_DO,
  output logic [C_FMAC_WIDTH-1:0]                  OpC_DO,
  output logic [C_RM_WIDTH-1:0]                    RM_DO,
  output logic                                     Valid_SO,
  output logic                                     En_SO,
  input  logic [C_FMAC_WIDTH-1:0]                  Res_DI,
  input  logic [C_FLAG_WIDTH-1:0]                  Flags_DI,
  output logic [C_FMAC_WIDTH-1:0]                  Res_DO,
  output logic [C_FLAG_WIDTH-1:0]                  Flags_DO,
  output logic [C_NUM_REQ-1:0]                     ResValid_SO,
  input  logic [C_NUM_REQ-1:0]                     ResReady_SI,
  input  logic                                     Flush_SI,
  output logic                                     Busy_SO
);

  localparam int unsigned TW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

  logic [C_LAT-1:0]         vld_pipe_q, vld_pipe_d;
  logic [C_LAT-1:0][TW-1:0] tag_pipe_q, tag_pipe_d;
  logic [TW-1:0]            prio_q, prio_d;

  logic [C_NUM_REQ-1:0] arb_gnt;
  logic [TW-1:0]        arb_idx;
  logic                 arb_vld;
  logic [TW-1:0]        last_tag;
  logic [TW-1:0]        sel;
  logic                 last_vld;
  logic                 stall;
  logic                 issue;

  rr_arb_tree_fmac #(
    .NUM_REQ (C_NUM_REQ),
    .IDX_W   (TW)
  ) u_rr (
    .req_i  (Req_SI),
    .prio_i (prio_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  // Stall when the oldest op cannot hand its result to its owner.
  always_comb begin
    last_vld = vld_pipe_q[C_LAT-1];
    last_tag = tag_pipe_q[C_LAT-1];
    stall    = last_vld & ~ResReady_SI[last_tag];
    issue    = arb_vld & ~stall & ~Flush_SI & ~Rst_RI;
  end

  // Next state: flush wipes valids even under stall; otherwise shift on enable.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    tag_pipe_d = tag_pipe_q;
    prio_d     = prio_q;
    if (!stall) begin
      for (int unsigned k = C_LAT - 1; k > 0; k--) begin
        vld_pipe_d[k] = vld_pipe_q[k-1];
        tag_pipe_d[k] = tag_pipe_q[k-1];
      end
      vld_pipe_d[0] = issue;
      tag_pipe_d[0] = arb_idx;
    end
    if (Flush_SI) vld_pipe_d = '0;
    if (issue) prio_d = TW'(wrap_inc(32'(arb_idx), C_NUM_REQ));
  end

  // Pipe tracking state and round-robin pointer.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      prio_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      prio_q     <= prio_d;
    end
  end

  // Output muxing; everything is forced quiet during reset except the enable.
  always_comb begin
    sel         = issue ? arb_idx : '0;
    Gnt_SO      = issue ? arb_gnt : '0;
    Valid_SO    = issue;
    En_SO       = Rst_RI | ~stall;
    OpA_DO      = Rst_RI ? '0 : OpA_DI[sel];
    OpB_DO      = Rst_RI ? '0 : OpB_DI[sel];
    OpC_DO      = Rst_RI ? '0 : OpC_DI[sel];
    RM_DO       = Rst_RI ? '0 : RM_DI[sel];
    Res_DO      = Rst_RI ? '0 : Res_DI;
    Flags_DO    = Rst_RI ? '0 : Flags_DI;
    Busy_SO     = ~Rst_RI & (|vld_pipe_q);
    ResValid_SO = '0;
    if (last_vld && !Flush_SI && !Rst_RI) ResValid_SO[last_tag] = 1'b1;
  end

endmodule

// File: doc/fmac_arbiter.md
FMAC_ARBITER -- requirements
Module: fmac_arbiter

Interface
REQ-001 SHALL have parameter C_NUM_REQ, default 4, number of requesters sharing one FMAC datapath (2..8).
REQ-002 SHALL have parameter C_LAT, default 3, datapath latency in enabled cycles from issue to result (1..8).
REQ-003 SHALL have one clock and a synchronous, active-high reset: Clk_CI  in  1  rising-edge clock.
REQ-004 SHALL have Rst_RI  in  1  synchronous active-high reset.
REQ-005 SHALL have Req_SI  in  C_NUM_REQ  per-requester operation request, held until granted.
REQ-006 SHALL have OpA_DI, OpB_DI, OpC_DI  in  C_NUM_REQ x C_FMAC_WIDTH  per-requester operands.
REQ-007 SHALL have RM_DI  in  C_NUM_REQ x 3  per-requester rounding mode.
REQ-008 SHALL have Gnt_SO  out  C_NUM_REQ  one-hot grant, combinational, issue accepted this cycle.
REQ-009 SHALL have OpA_DO, OpB_DO, OpC_DO  out  C_FMAC_WIDTH  operands muxed to datapath.
REQ-010 SHALL have RM_DO  out  3  muxed rounding mode.
REQ-011 SHALL have Valid_SO  out  1  issue strobe to datapath stage 0.
REQ-012 SHALL have En_SO  out  1  datapath pipeline-register enable; low freezes all stages.
REQ-013 SHALL have Res_DI  in  C_FMAC_WIDTH and Flags_DI  in  5  datapath result and exception flags.
REQ-014 SHALL have Res_DO  out  C_FMAC_WIDTH and Flags_DO  out  5  result and flags broadcast to all requesters.
REQ-015 SHALL have ResValid_SO  out  C_NUM_REQ  one-hot result valid; ResReady_SI  in  C_NUM_REQ  per-requester result ready.
REQ-016 SHALL have Flush_SI  in  1  discard all in-flight operations; Busy_SO  out  1  any operation in flight.

Function
REQ-017 SHALL track each in-flight operation in a C_LAT-deep shift register of {valid, tag}; tag width $clog2(C_NUM_REQ).
REQ-018 SHALL assert Stall when the last stage is valid and ResReady_SI[tag] is low; En_SO = ~Stall.
REQ-019 SHALL advance the shift register only when En_SO is high; stage 0 loads {issue, granted tag}.
REQ-020 SHALL issue (Valid_SO=1, one Gnt_SO bit set) iff any Req_SI bit is set, Stall is low and Flush_SI is low.
REQ-021 SHALL select the grant round-robin: lowest-indexed requesting bit at or above pointer Prio_SP, wrapping modulo C_NUM_REQ.
REQ-022 SHALL update Prio_SP to (granted index + 1) mod C_NUM_REQ on issue only; unchanged otherwise.
REQ-023 SHALL drive OpA/B/C_DO and RM_DO from the granted requester, and from requester 0 when no grant.
REQ-024 SHALL drive ResValid_SO[tag] = last-stage valid & ~Flush_SI, all other bits zero; Res_DO/Flags_DO = Res_DI/Flags_DI.
REQ-025 SHALL complete a transfer when ResValid_SO[i] and ResReady_SI[i] are both high; the stage then advances the same cycle.
REQ-026 SHALL sustain one issue per cycle with no bubbles while no stall occurs; issue-to-ResValid latency is exactly C_LAT cycles.
REQ-027 SHALL on Flush_SI clear all stage valid bits at the next edge, suppress grant and ResValid that cycle, and keep Prio_SP.
REQ-028 SHALL keep the shift register unchanged during a stall, including stage 0, and deliver no grant.
REQ-029 SHALL drive Busy_SO = OR of all stage valid bits.
REQ-030 SHALL ignore a request withdrawn before grant; no state is recorded for it.

Reset
REQ-031 SHALL on Rst_RI clear all stage valid bits and tags to 0, and set Prio_SP to 0.
REQ-032 SHALL drive all outputs to 0 while Rst_RI is high, except En_SO=1; reset mid-operation drops in-flight results silently.

Structure
REQ-033 SHALL take C_FMAC_WIDTH and the rounding-mode width from the shared fpu_defs_fmac package; C_NUM_REQ and C_LAT stay module parameters.
REQ-034 SHALL implement round-robin selection as sub-module rr_arb_tree_fmac (Req, Prio -> one-hot Gnt, index), purely combinational.

Verification
REQ-035 Reset: Rst_RI=1 for 2 cycles with all Req_SI=1 -> Gnt_SO=0, ResValid_SO=0, Busy_SO=0, En_SO=1.
REQ-036 Round-robin: Req_SI=4'b1111 held, ResReady all 1 -> grants 0,1,2,3,0 on consecutive cycles; ResValid follows 3 cycles later in the same order.
REQ-037 Stall: requester 2 in last stage, ResReady_SI[2]=0 for 4 cycles -> En_SO=0, no grants, ResValid_SO=4'b0100 held; released with ready=1 on cycle 5.
REQ-038 Flush: 3 ops in flight, Flush_SI=1 for 1 cycle -> no ResValid thereafter, Busy_SO=0 next cycle, Prio_SP unchanged.
REQ-039 Wrap: Prio_SP=3, Req_SI=4'b0011 -> Gnt_SO=4'b0001, Prio_SP becomes 1.
REQ-040 Reset mid-operation: Rst_RI during 2 in-flight ops -> no ResValid for those ops; next grant goes to requester 0 if requesting.
